// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the fetch PC, picks the next PC from the
// sequential, branch, exception-entry and ERET sources, and holds EPC and the handler state.
module fetch_seq #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_4FFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        eret,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        adel,
  output logic [31:0] epc,
  output logic        in_handler,
  output logic        exc_lost,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] epc_reg, epc_next;
  logic [31:0] fetch_cnt_reg, fetch_cnt_next;
  logic [31:0] pc_seq;
  logic        adel_int;
  logic        fetch_valid_int;

  // Modular increment: 0xFFFF_FFFC wraps to 0 and adel reports it.
  assign pc_seq = pc_reg + 32'd4;

  assign adel_int = (pc_reg[1:0] != 2'b00) | (pc_reg < IM_LO) | (pc_reg > IM_HI);
  assign fetch_valid_int = (state_reg != BOOT) & ~adel_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= BOOT;
      pc_reg        <= RESET_PC;
      epc_reg       <= 32'h0000_0000;
      fetch_cnt_reg <= 32'h0000_0000;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      epc_reg       <= epc_next;
      fetch_cnt_reg <= fetch_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    epc_next       = epc_reg;
    fetch_cnt_next = fetch_cnt_reg;
    exc_lost       = 1'b0;

    if (fetch_valid_int && !stall) begin
      fetch_cnt_next = fetch_cnt_reg + 32'd1;
    end

    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        // Exception entry overrides stall and any concurrent branch; eret is meaningless here.
        if (exc_req) begin
          state_next = HANDLER;
          pc_next    = HANDLER_PC;
          epc_next   = exc_pc;
        end else if (stall) begin
          pc_next = pc_reg;
        end else if (br_taken) begin
          pc_next = br_target;
        end else begin
          pc_next = pc_seq;
        end
      end
      HANDLER: begin
        // Only one handler level: a new request is dropped and reported.
        exc_lost = exc_req;
        if (eret) begin
          state_next = RUN;
          pc_next    = epc_reg;
        end else if (stall) begin
          pc_next = pc_reg;
        end else if (br_taken) begin
          pc_next = br_target;
        end else begin
          pc_next = pc_seq;
        end
      end
      default: begin
        state_next = BOOT;
        pc_next    = RESET_PC;
      end
    endcase
  end

  assign pc          = pc_reg;
  assign epc         = epc_reg;
  assign fetch_cnt   = fetch_cnt_reg;
  assign adel        = adel_int;
  assign fetch_valid = fetch_valid_int;
  assign in_handler  = (state_reg == HANDLER);

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: each cycle's stimulus pushes its hand-computed
// expected outputs into a queue that an independent monitor pops and checks.
module tb_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        eret;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        adel;
  logic [31:0] epc;
  logic        in_handler;
  logic        exc_lost;
  logic [31:0] fetch_cnt;

  fetch_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .exc_req    (exc_req),
    .exc_pc     (exc_pc),
    .eret       (eret),
    .pc         (pc),
    .fetch_valid(fetch_valid),
    .adel       (adel),
    .epc        (epc),
    .in_handler (in_handler),
    .exc_lost   (exc_lost),
    .fetch_cnt  (fetch_cnt)
  );

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        fv;
    logic        adel;
    logic [31:0] epc;
    logic        inh;
    logic        lost;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h expected %h", id, name, act, req);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest queued expectation.
  initial begin
    forever begin
      @(sample_ev);
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: got sample with empty queue expected an entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk32("pc",          e.id, pc,                  e.pc);
        chk32("fetch_valid", e.id, {31'd0, fetch_valid}, {31'd0, e.fv});
        chk32("adel",        e.id, {31'd0, adel},        {31'd0, e.adel});
        chk32("epc",         e.id, epc,                 e.epc);
        chk32("in_handler",  e.id, {31'd0, in_handler},  {31'd0, e.inh});
        chk32("exc_lost",    e.id, {31'd0, exc_lost},    {31'd0, e.lost});
        chk32("fetch_cnt",   e.id, fetch_cnt,           e.cnt);
        $display("vec%0d pc=%h fv=%0b adel=%0b epc=%h inh=%0b lost=%0b cnt=%0d",
                 e.id, pc, fetch_valid, adel, epc, in_handler, exc_lost, fetch_cnt);
      end
    end
  end

  int vec_id = 0;

  task automatic expect_now(input logic [31:0] e_pc, input logic e_fv, input logic e_adel,
                            input logic [31:0] e_epc, input logic e_inh, input logic e_lost,
                            input logic [31:0] e_cnt);
    exp_t e;
    e.id = vec_id; e.pc = e_pc; e.fv = e_fv; e.adel = e_adel; e.epc = e_epc;
    e.inh = e_inh; e.lost = e_lost; e.cnt = e_cnt;
    exp_q.push_back(e);
    vec_id++;
    -> sample_ev;
  endtask

  // One cycle: drive inputs just after the falling edge, queue what this cycle must show.
  task automatic step(input logic s, input logic b, input logic [31:0] t, input logic x,
                      input logic [31:0] xp, input logic r,
                      input logic [31:0] e_pc, input logic e_fv, input logic e_adel,
                      input logic [31:0] e_epc, input logic e_inh, input logic e_lost,
                      input logic [31:0] e_cnt);
    @(negedge clk);
    stall = s; br_taken = b; br_target = t; exc_req = x; exc_pc = xp; eret = r;
    expect_now(e_pc, e_fv, e_adel, e_epc, e_inh, e_lost, e_cnt);
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; br_taken = 0; br_target = 0; exc_req = 0; exc_pc = 0; eret = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    //   stall br tgt           exc xpc           eret | pc            fv adel epc           inh lost cnt
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 0, 0, 32'h0,        0, 0, 0);   // BOOT
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 1, 0, 32'h0,        0, 0, 0);
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3004, 1, 0, 32'h0,        0, 0, 1);
    step(1, 1, 32'h3100,     0, 32'h0,        0, 32'h0000_3008, 1, 0, 32'h0,        0, 0, 2);   // stalled branch
    step(0, 1, 32'h3100,     0, 32'h0,        0, 32'h0000_3008, 1, 0, 32'h0,        0, 0, 2);
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3100, 1, 0, 32'h0,        0, 0, 3);
    step(0, 1, 32'h3010,     0, 32'h0,        0, 32'h0000_3104, 1, 0, 32'h0,        0, 0, 4);
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3010, 1, 0, 32'h0,        0, 0, 5);
    step(1, 1, 32'h3200,     1, 32'h3010,     0, 32'h0000_3014, 1, 0, 32'h0,        0, 0, 6);   // exc wins
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_4180, 1, 0, 32'h3010,     1, 0, 6);
    step(1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_4184, 1, 0, 32'h3010,     1, 0, 7);   // eret under stall
    step(0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_3010, 1, 0, 32'h3010,     0, 0, 7);   // eret in RUN ignored
    step(0, 0, 32'h0,        1, 32'h3020,     0, 32'h0000_3014, 1, 0, 32'h3010,     0, 0, 8);
    step(0, 0, 32'h0,        1, 32'h3ABC,     1, 32'h0000_4180, 1, 0, 32'h3020,     1, 1, 9);   // exc+eret
    step(0, 0, 32'h0,        1, 32'h3030,     0, 32'h0000_3020, 1, 0, 32'h3020,     0, 0, 10);
    step(0, 0, 32'h0,        1, 32'h3999,     0, 32'h0000_4180, 1, 0, 32'h3030,     1, 1, 11);  // nested lost
    step(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_4184, 1, 0, 32'h3030,     1, 0, 12);
    step(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_4184, 1, 0, 32'h3030,     1, 0, 12);
    step(0, 1, 32'h4FFC,     0, 32'h0,        0, 32'h0000_4184, 1, 0, 32'h3030,     1, 0, 12);
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_4FFC, 1, 0, 32'h3030,     1, 0, 13);  // top of window
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_5000, 0, 1, 32'h3030,     1, 0, 14);  // beyond window
    step(0, 1, 32'h3002,     0, 32'h0,        0, 32'h0000_5004, 0, 1, 32'h3030,     1, 0, 14);
    step(0, 1, 32'hFFFF_FFFC, 0, 32'h0,       0, 32'h0000_3002, 0, 1, 32'h3030,     1, 0, 14);  // misaligned
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'hFFFF_FFFC, 0, 1, 32'h3030,     1, 0, 14);
    step(0, 1, 32'h4180,     0, 32'h0,        0, 32'h0000_0000, 0, 1, 32'h3030,     1, 0, 14);  // wrapped
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_4180, 1, 0, 32'h3030,     1, 0, 14);
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_4184, 1, 0, 32'h3030,     1, 0, 15);
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_4188, 1, 0, 32'h3030,     1, 0, 16);
    // Asynchronous reset between edges while in the handler.
    #2 rst_n = 1'b0;
    expect_now(32'h0000_3000, 0, 0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 0, 0, 32'h0,        0, 0, 0);
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 1, 0, 32'h0,        0, 0, 0);
    step(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3004, 1, 0, 32'h0,        0, 0, 1);
    @(negedge clk);
    #3;
    stim_done = 1;
  end

  initial begin
    wait (stim_done);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer for the multi-cycle-free MIPS core. It owns the program counter that addresses the instruction ROM (word window 0x0000_3000–0x0000_4FFC, indexed by pc[16:2]) and selects the next PC from sequential, branch/jump, exception-entry and ERET sources. It also holds EPC and a single-level handler state, and flags illegal fetch addresses. It sits between the decode/CP0 control logic and the instruction ROM.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- HANDLER_PC, 32'h0000_4180, exception entry address
- IM_LO, 32'h0000_3000, lowest legal fetch address
- IM_HI, 32'h0000_4FFC, highest legal fetch address
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold current PC (pipeline stall)
- br_taken  in  1  branch/jump redirect request
- br_target  in  32  redirect address
- exc_req  in  1  exception/interrupt request from CP0 logic
- exc_pc  in  32  PC to save as EPC on exception entry
- eret  in  1  return-from-exception request
- pc  out  32  current fetch address to instruction ROM
- fetch_valid  out  1  pc is a valid fetch this cycle
- adel  out  1  pc misaligned or outside [IM_LO, IM_HI]
- epc  out  32  saved exception PC
- in_handler  out  1  state is HANDLER
- exc_lost  out  1  one-cycle pulse: exc_req dropped (nested)
- fetch_cnt  out  32  count of accepted fetches

## Operation
- States: BOOT, RUN, HANDLER. Reset → BOOT.
- BOOT: lasts exactly one cycle after rst_n deasserts; pc=RESET_PC, fetch_valid=0; next state RUN, pc unchanged.
- RUN, next-PC priority (highest first): exc_req → pc<=HANDLER_PC, epc<=exc_pc, state HANDLER; stall → hold pc; br_taken → pc<=br_target; else pc<=pc+4. eret in RUN ignored (treated as no request).
- HANDLER priority: eret → pc<=epc, state RUN; stall → hold; br_taken → pc<=br_target; else pc+4. exc_req in HANDLER is ignored: exc_lost=1 for that cycle, epc unchanged.
- exc_req and eret act regardless of stall; br_taken is ignored while stall=1 (requester holds it).
- Simultaneous exc_req+br_taken in RUN: exception wins, branch discarded. Simultaneous exc_req+eret in HANDLER: eret taken, exc_lost=1.
- adel = (pc[1:0]!=0) | (pc<IM_LO) | (pc>IM_HI), unsigned compare, combinational from registered pc.
- fetch_valid = (state!=BOOT) & ~adel.
- fetch_cnt increments by 1 each cycle fetch_valid & ~stall; wraps 0xFFFF_FFFF→0; not cleared by exceptions.
- pc+4 is 32-bit modular; 0xFFFF_FFFC+4 = 0 (adel then flags it).
- adel does not redirect by itself; CP0 logic raises exc_req in response.

## Timing
- Reset values: pc=RESET_PC, epc=0, state=BOOT, in_handler=0, exc_lost=0, fetch_cnt=0, fetch_valid=0, adel=0.
- rst_n low mid-operation forces reset values immediately (asynchronous), regardless of clk.
- All redirects have 1-cycle latency: request sampled at edge N, new pc visible after edge N, fetch_valid high that same cycle (no bubble).
- epc and in_handler update on the same edge as pc on exception entry; cleared in_handler on the ERET edge; epc retains value after ERET.
- exc_lost is a registered-free combinational pulse, high only in the cycle exc_req is sampled in HANDLER.
- stall=1 for K cycles: pc constant K cycles, fetch_cnt unchanged.

## Test plan
- Reset release, no requests, 4 cycles → pc 0x3000 (fetch_valid=0), 0x3000, 0x3004, 0x3008; fetch_cnt=2 after third cycle's edge.
- br_taken=1, br_target=0x3100 at pc=0x3008 → next pc 0x3100; same with stall=1 → pc stays 0x3008.
- exc_req with exc_pc=0x3010 at pc=0x3014 while stall=1 → pc 0x4180, epc 0x3010, in_handler=1; then eret → pc 0x3010, in_handler=0.
- In HANDLER, exc_req and eret same cycle → pc=epc, exc_lost=1, epc unchanged; exc_req alone in HANDLER → exc_lost=1, pc=pc+4.
- br_target=0x5000 → adel=1, fetch_valid=0, fetch_cnt frozen; br_target=0x3002 → adel=1; pc 0x4FFC → adel=0.
- Assert rst_n=0 between edges while in HANDLER at pc 0x4188 → pc 0x3000, state BOOT, epc 0, fetch_cnt 0 immediately.
